cnu_serial: RTL and testbench
=============================

Name: cnu_serial

Overview:
- Check Node Unit that terminates the VNU-to-CNU message path of the LDPC decoder.
- Accepts DC serial 6-bit VNU messages for one parity check, in the form {hard_decision, sign, mag[3:0]}.
- Returns DC serial 5-bit sign-magnitude messages, {sign, mag[3:0]}, in the format the VNU consumes on its X inputs.
- Computes the message magnitudes with min-sum and also produces the check's parity (syndrome) bit from the VNU hard decisions.

Parameters:
- DC, 6, check-node degree: messages per check (2..16).
- MAG_W, 4, magnitude width of the messages.
- IDX_W, $clog2(DC), width of the message index.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_msg valid.
- in_ready  out  1  block can accept in_msg.
- in_msg  in  MAG_W+2  {hard_decision, sign, magnitude} from VNU.
- out_valid  out  1  out_msg valid.
- out_ready  in  1  downstream accepts out_msg.
- out_msg  out  MAG_W+1  {sign, magnitude} to VNU.
- out_idx  out  IDX_W  index (0..DC-1) of the VNU edge that out_msg belongs to.
- syndrome  out  1  XOR of the DC hard decisions; 1 = check unsatisfied.
- syndrome_valid  out  1  one-cycle pulse when syndrome updates.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=COLLECT, in_ready=1, out_valid=0, out_msg=0, out_idx=0, syndrome=0, syndrome_valid=0.
  - min1 = min2 = all-ones; min_idx=0; sign_prod=0; hd_par=0; cnt=0; sign_mem=0.
- Handshakes: a transfer occurs when valid&&ready on the same posedge. in_ready=1 only in COLLECT. out_valid=1 only in EMIT.
- COLLECT, on each input transfer:
  - sign_mem[cnt] <= sign.
  - sign_prod ^= sign; hd_par ^= hard_decision.
  - If mag < min1: min2 <= min1, min1 <= mag, min_idx <= cnt.
  - Else if mag < min2: min2 <= mag.
  - Comparisons are strict, so on ties min_idx keeps the first occurrence.
  - cnt increments.
- Transfer with cnt==DC-1:
  - Go to EMIT and clear cnt.
  - syndrome <= hd_par ^ hard_decision, with syndrome_valid=1 for exactly that following cycle.
- EMIT, for edge idx = cnt:
  - out_msg.sign = sign_prod ^ sign_mem[idx] (extrinsic sign).
  - out_msg.mag = (idx==min_idx) ? min2 : min1 (after the optional offset).
  - out_idx = idx. out_msg/out_idx are driven combinationally from state and stay stable while out_valid && !out_ready.
- On each output transfer cnt increments. Transfer at idx DC-1:
  - Return to COLLECT.
  - Clear min1/min2 to all-ones; clear sign_prod, hd_par, cnt, min_idx.
- Latency: out_valid rises the cycle after the last input transfer. Best-case throughput is 2*DC cycles per check.
- A negative-zero input (sign=1, mag=0) is a legal input; its sign participates in the product.
- No input is accepted during EMIT, so EMIT and COLLECT never overlap. in_valid during EMIT is simply held off.
- Reset asserted mid-COLLECT or mid-EMIT immediately aborts the check and returns to the reset values. No partial output is emitted afterwards.
- DC=2 is legal: each edge receives the other edge's magnitude.

Optional Feature:
- Macro: CNU_OFFSET_MIN_SUM_EN.
- Defined: emitted magnitude = max(selected_min - CNU_OFFSET, 0), where the localparam CNU_OFFSET = 1 (offset min-sum). The subtraction saturates at 0 and the sign is unchanged.
- Undefined: plain min-sum; magnitude = selected min.

Decomposition:
- Package ldpc_pkg:
  - MAG_W.
  - VNU_MSG_W=6 and CNU_MSG_W=5.
  - Field index constants HD_BIT=5, VNU_SIGN_BIT=4, CNU_SIGN_BIT=4.
  - CNU_OFFSET.
  - Typedef cnu_state_t {COLLECT, EMIT}.
- One sub-module, min2_tracker: combinational compare/update of (min1, min2, min_idx) given a new mag and idx. It is instantiated once; registers stay in cnu_serial.

Test Plan:
- DC=6, mags 5,3,7,3,9,6, all signs 0, hd all 1, out_ready=1 -> min1=3, min2=3, min_idx=1; outputs mag 3,3,3,3,3,3, all signs 0; syndrome=0 with one-cycle syndrome_valid.
- Mags 8,2,4,11,6,9; signs 1,0,0,1,1,0; hd 1,0,1,1,0,0 -> sign_prod=1; mags 2,4,2,2,2,2; signs 0,1,1,0,0,1; syndrome=1.
- Backpressure: out_ready toggles 0/1 each cycle -> out_msg/out_idx stay stable while stalled; all 6 outputs in order 0..5; in_ready=0 throughout EMIT.
- Back-to-back checks with in_valid held high -> the second check's first message is accepted the cycle after the first check's last output; min state does not leak between checks.
- rst_n pulsed low after 3 inputs, then a new full check -> output is the new check only; out_valid never asserted for the aborted one.
- With CNU_OFFSET_MIN_SUM_EN, mags 1,0,5,5,5,5 -> outputs 0,0,0,0,0,0 (offset saturates at 0). Without it, the same inputs give 0,1,0,0,0,0.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants, message field positions and the check-node state type.
// CNU_OFFSET is only used by builds that define CNU_OFFSET_MIN_SUM_EN.
package ldpc_pkg;

    localparam int MAG_W        = 4;
    localparam int VNU_MSG_W    = 6;
    localparam int CNU_MSG_W    = 5;
    localparam int HD_BIT       = 5;
    localparam int VNU_SIGN_BIT = 4;
    localparam int CNU_SIGN_BIT = 4;
    localparam int CNU_OFFSET   = 1;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cnu_state_t;

endpackage

// File: rtl/min2_tracker.sv
// Combinational min-sum tracker: folds one new magnitude into the running
// (min1, min2, min_idx) triple. Strict compares keep the first index on ties.
module min2_tracker #(
    parameter int MAG_W = 4,
    parameter int IDX_W = 3
) (
    input  logic [MAG_W-1:0] min1,
    input  logic [MAG_W-1:0] min2,
    input  logic [IDX_W-1:0] min_idx,
    input  logic [MAG_W-1:0] mag,
    input  logic [IDX_W-1:0] idx,
    output logic [MAG_W-1:0] min1_nxt,
    output logic [MAG_W-1:0] min2_nxt,
    output logic [IDX_W-1:0] min_idx_nxt
);
    import ldpc_pkg::*;

    always_comb begin
        min1_nxt    = min1;
        min2_nxt    = min2;
        min_idx_nxt = min_idx;
        if (mag < min1) begin
            min2_nxt    = min1;
            min1_nxt    = mag;
            min_idx_nxt = idx;
        end else if (mag < min2) begin
            min2_nxt = mag;
        end
    end

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node: collects DC VNU messages, then emits DC extrinsic
// messages plus the check's syndrome. Define CNU_OFFSET_MIN_SUM_EN for offset min-sum.
module cnu_serial #(
    parameter int DC    = 6,
    parameter int MAG_W = 4,
    parameter int IDX_W = $clog2(DC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W+1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W:0]   out_msg,
    output logic [IDX_W-1:0] out_idx,
    output logic             syndrome,
    output logic             syndrome_valid
);
    import ldpc_pkg::*;

    cnu_state_t       state;
    logic [MAG_W-1:0] min1;
    logic [MAG_W-1:0] min2;
    logic [IDX_W-1:0] min_idx;
    logic [MAG_W-1:0] min1_nxt;
    logic [MAG_W-1:0] min2_nxt;
    logic [IDX_W-1:0] min_idx_nxt;
    logic [IDX_W-1:0] cnt;
    logic [DC-1:0]    sign_mem;
    logic             sign_prod;
    logic             hd_par;

    logic             in_hd;
    logic             in_sign;
    logic [MAG_W-1:0] in_mag;
    logic             in_fire;
    logic             out_fire;
    logic             last_idx;
    logic [MAG_W-1:0] mag_sel;
    logic [MAG_W-1:0] mag_out;

    assign in_hd    = in_msg[MAG_W+1];
    assign in_sign  = in_msg[MAG_W];
    assign in_mag   = in_msg[MAG_W-1:0];

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_idx  = (cnt == IDX_W'(DC - 1));

    min2_tracker #(
        .MAG_W (MAG_W),
        .IDX_W (IDX_W)
    ) u_min2_tracker (
        .min1        (min1),
        .min2        (min2),
        .min_idx     (min_idx),
        .mag         (in_mag),
        .idx         (cnt),
        .min1_nxt    (min1_nxt),
        .min2_nxt    (min2_nxt),
        .min_idx_nxt (min_idx_nxt)
    );

    // The min state is cleared when the last output leaves, so a new check starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= COLLECT;
            min1           <= '1;
            min2           <= '1;
            min_idx        <= '0;
            cnt            <= '0;
            sign_mem       <= '0;
            sign_prod      <= 1'b0;
            hd_par         <= 1'b0;
            syndrome       <= 1'b0;
            syndrome_valid <= 1'b0;
        end else begin
            syndrome_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (in_fire) begin
                        sign_mem[cnt] <= in_sign;
                        sign_prod     <= sign_prod ^ in_sign;
                        hd_par        <= hd_par ^ in_hd;
                        min1          <= min1_nxt;
                        min2          <= min2_nxt;
                        min_idx       <= min_idx_nxt;
                        if (last_idx) begin
                            state          <= EMIT;
                            cnt            <= '0;
                            syndrome       <= hd_par ^ in_hd;
                            syndrome_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (last_idx) begin
                            state     <= COLLECT;
                            cnt       <= '0;
                            min1      <= '1;
                            min2      <= '1;
                            min_idx   <= '0;
                            sign_prod <= 1'b0;
                            hd_par    <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // The edge that owns min1 must see min2, everyone else sees min1.
    always_comb begin
        mag_sel = (cnt == min_idx) ? min2 : min1;
`ifdef CNU_OFFSET_MIN_SUM_EN
        mag_out = (mag_sel > MAG_W'(CNU_OFFSET)) ? (mag_sel - MAG_W'(CNU_OFFSET)) : '0;
`else
        mag_out = mag_sel;
`endif
    end

    assign out_msg = (state == EMIT) ? {sign_prod ^ sign_mem[cnt], mag_out} : '0;
    assign out_idx = (state == EMIT) ? cnt : '0;

endmodule

// File: tb/tb_cnu_serial.sv
// Testbench for cnu_serial: directed and random checks against an extrinsic min/sign model.
// Honours CNU_OFFSET_MIN_SUM_EN in the same way as the design.
module tb_cnu_serial;
    import ldpc_pkg::*;

    localparam int DC = 6;
    localparam int IW = $clog2(DC);

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [VNU_MSG_W-1:0] in_msg;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNU_MSG_W-1:0] out_msg;
    logic [IW-1:0]        out_idx;
    logic                 syndrome;
    logic                 syndrome_valid;

    int n_cmp;
    int n_err;

    int in_mag [DC];
    int in_sgn [DC];
    int in_hd  [DC];
    int exp_mag[DC];
    int exp_sgn[DC];
    int exp_syn;

    logic [CNU_MSG_W-1:0] got_msg[DC];
    int                   got_idx[DC];
    int                   got_n;
    int                   stall_err;
    int                   emit_err;
    int                   sv_cnt;
    int                   ready_mode;
    logic [VNU_MSG_W-1:0] next_first;

    cnu_serial #(
        .DC    (DC),
        .MAG_W (MAG_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_msg         (in_msg),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_msg        (out_msg),
        .out_idx        (out_idx),
        .syndrome       (syndrome),
        .syndrome_valid (syndrome_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each edge gets the minimum and sign product of all the other edges.
    task automatic compute_expected();
        exp_syn = 0;
        for (int j = 0; j < DC; j++) exp_syn ^= in_hd[j];
        for (int i = 0; i < DC; i++) begin
            int m;
            int s;
            m = (1 << MAG_W) - 1;
            s = 0;
            for (int j = 0; j < DC; j++) begin
                if (j != i) begin
                    if (in_mag[j] < m) m = in_mag[j];
                    s ^= in_sgn[j];
                end
            end
`ifdef CNU_OFFSET_MIN_SUM_EN
            m = (m > CNU_OFFSET) ? m - CNU_OFFSET : 0;
`endif
            exp_mag[i] = m;
            exp_sgn[i] = s;
        end
    endtask

    function automatic logic [VNU_MSG_W-1:0] mk_msg(input int i);
        return {1'(in_hd[i]), 1'(in_sgn[i]), MAG_W'(in_mag[i])};
    endfunction

    function automatic logic [CNU_MSG_W-1:0] exp_msg(input int i);
        return {1'(exp_sgn[i]), MAG_W'(exp_mag[i])};
    endfunction

    task automatic randomize_check(input int lo, input int hi);
        for (int i = 0; i < DC; i++) begin
            in_mag[i] = $urandom_range(hi, lo);
            in_sgn[i] = $urandom_range(1, 0);
            in_hd[i]  = $urandom_range(1, 0);
        end
    endtask

    // Drives n messages from the in_* arrays; called and returns on a negedge.
    task automatic send_check(input int n, input bit hold);
        for (int i = 0; i < n; i++) begin
            int waited;
            waited   = 0;
            in_valid = 1'b1;
            in_msg   = mk_msg(i);
            while (!in_ready && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL send_timeout msg %0d: in_ready=%b, required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (hold) in_msg = next_first;
        else in_valid = 1'b0;
    endtask

    // Gathers DC outputs while recording stall stability and EMIT-phase handshake state.
    task automatic collect_check();
        int                   cycles;
        bit                   stalled;
        logic [CNU_MSG_W-1:0] s_msg;
        logic [IW-1:0]        s_idx;
        cycles    = 0;
        stalled   = 1'b0;
        s_msg     = '0;
        s_idx     = '0;
        got_n     = 0;
        stall_err = 0;
        emit_err  = 0;
        sv_cnt    = 0;
        while (got_n < DC && cycles < 200) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cycles % 2) == 1);
                default: out_ready = 1'($urandom_range(1, 0));
            endcase
            if (syndrome_valid) sv_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) emit_err++;
            if (stalled && (out_msg !== s_msg || out_idx !== s_idx)) stall_err++;
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                got_msg[got_n] = out_msg;
                got_idx[got_n] = int'(out_idx);
                got_n++;
            end else if (out_valid) begin
                stalled = 1'b1;
                s_msg   = out_msg;
                s_idx   = out_idx;
            end
            @(negedge clk);
            cycles++;
        end
        if (got_n < DC) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL collect_timeout: got %0d outputs, required %0d", got_n, DC);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp += 6;
        if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (out_msg !== '0) begin n_err++; $display("[TB] FAIL reset_out_msg: got %h, required 0", out_msg); end
        if (out_idx !== '0) begin n_err++; $display("[TB] FAIL reset_out_idx: got %0d, required 0", out_idx); end
        if (syndrome !== 1'b0) begin n_err++; $display("[TB] FAIL reset_syndrome: got %b, required 0", syndrome); end
        if (syndrome_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_syn_valid: got %b, required 0", syndrome_valid); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_positive();
        in_mag = '{5, 3, 7, 3, 9, 6};
        in_sgn = '{0, 0, 0, 0, 0, 0};
        in_hd  = '{1, 1, 1, 1, 1, 1};
        ready_mode = 0;
        compute_expected();
        send_check(DC, 1'b0);
        collect_check();
        for (int i = 0; i < DC; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_msg[i] !== exp_msg(i)) begin
                n_err++;
                $display("[TB] FAIL all_positive edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", i, got_idx[i], got_msg[i], i, exp_msg(i));
            end
        end
        n_cmp += 3;
        if (syndrome !== 1'(exp_syn)) begin n_err++; $display("[TB] FAIL all_positive_syndrome: got %b, required %0d", syndrome, exp_syn); end
        if (sv_cnt !== 1) begin n_err++; $display("[TB] FAIL all_positive_syn_pulse: got %0d cycles, required 1", sv_cnt); end
        if (emit_err !== 0) begin n_err++; $display("[TB] FAIL all_positive_emit_hs: got %0d bad cycles, required 0", emit_err); end
    endtask

    task automatic test_mixed_signs();
        in_mag = '{8, 2, 4, 11, 6, 9};
        in_sgn = '{1, 0, 0, 1, 1, 0};
        in_hd  = '{1, 0, 1, 1, 0, 0};
        ready_mode = 0;
        compute_expected();
        send_check(DC, 1'b0);
        collect_check();
        for (int i = 0; i < DC; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_msg[i] !== exp_msg(i)) begin
                n_err++;
                $display("[TB] FAIL mixed_signs edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", i, got_idx[i], got_msg[i], i, exp_msg(i));
            end
        end
        n_cmp += 2;
        if (syndrome !== 1'(exp_syn)) begin n_err++; $display("[TB] FAIL mixed_signs_syndrome: got %b, required %0d", syndrome, exp_syn); end
        if (sv_cnt !== 1) begin n_err++; $display("[TB] FAIL mixed_signs_syn_pulse: got %0d cycles, required 1", sv_cnt); end
    endtask

    task automatic test_backpressure();
        randomize_check(0, 15);
        ready_mode = 1;
        compute_expected();
        send_check(DC, 1'b0);
        collect_check();
        for (int i = 0; i < DC; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_msg[i] !== exp_msg(i)) begin
                n_err++;
                $display("[TB] FAIL backpressure edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", i, got_idx[i], got_msg[i], i, exp_msg(i));
            end
        end
        n_cmp += 3;
        if (stall_err !== 0) begin n_err++; $display("[TB] FAIL backpressure_stable: got %0d unstable stalls, required 0", stall_err); end
        if (emit_err !== 0) begin n_err++; $display("[TB] FAIL backpressure_in_ready: got %0d bad cycles, required 0", emit_err); end
        if (syndrome !== 1'(exp_syn)) begin n_err++; $display("[TB] FAIL backpressure_syndrome: got %b, required %0d", syndrome, exp_syn); end
    endtask

    task automatic test_offset_saturation();
        logic [CNU_MSG_W-1:0] lit[DC];
        in_mag = '{1, 0, 5, 5, 5, 5};
        in_sgn = '{0, 1, 0, 0, 0, 0};
        in_hd  = '{0, 0, 0, 0, 0, 0};
`ifdef CNU_OFFSET_MIN_SUM_EN
        lit = '{5'h10, 5'h00, 5'h10, 5'h10, 5'h10, 5'h10};
`else
        lit = '{5'h10, 5'h01, 5'h10, 5'h10, 5'h10, 5'h10};
`endif
        ready_mode = 0;
        send_check(DC, 1'b0);
        collect_check();
        for (int i = 0; i < DC; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_msg[i] !== lit[i]) begin
                n_err++;
                $display("[TB] FAIL offset_neg_zero edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", i, got_idx[i], got_msg[i], i, lit[i]);
            end
        end
        n_cmp++;
        if (syndrome !== 1'b0) begin n_err++; $display("[TB] FAIL offset_syndrome: got %b, required 0", syndrome); end
    endtask

    task automatic test_back_to_back();
        int b_mag[DC];
        int b_sgn[DC];
        int b_hd [DC];
        randomize_check(0, 3);
        for (int i = 0; i < DC; i++) begin
            b_mag[i] = $urandom_range(15, 8);
            b_sgn[i] = $urandom_range(1, 0);
            b_hd[i]  = $urandom_range(1, 0);
        end
        next_first = {1'(b_hd[0]), 1'(b_sgn[0]), MAG_W'(b_mag[0])};
        ready_mode = 0;
        compute_expected();
        send_check(DC, 1'b1);
        collect_check();
        for (int i = 0; i < DC; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_msg[i] !== exp_msg(i)) begin
                n_err++;
                $display("[TB] FAIL b2b_first edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", i, got_idx[i], got_msg[i], i, exp_msg(i));
            end
        end
        n_cmp += 2;
        if (emit_err !== 0) begin n_err++; $display("[TB] FAIL b2b_held_off: got %0d bad cycles, required 0", emit_err); end
        if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_accept_next: in_ready=%b, required 1", in_ready); end
        in_mag = b_mag;
        in_sgn = b_sgn;
        in_hd  = b_hd;
        compute_expected();
        send_check(DC, 1'b0);
        collect_check();
        for (int i = 0; i < DC; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_msg[i] !== exp_msg(i)) begin
                n_err++;
                $display("[TB] FAIL b2b_second edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", i, got_idx[i], got_msg[i], i, exp_msg(i));
            end
        end
        n_cmp++;
        if (syndrome !== 1'(exp_syn)) begin n_err++; $display("[TB] FAIL b2b_syndrome: got %b, required %0d", syndrome, exp_syn); end
    endtask

    task automatic test_abort_reset();
        int stray;
        randomize_check(0, 2);
        in_hd = '{1, 0, 0, 0, 0, 0};
        send_check(3, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL abort_in_ready: got %b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL abort_out_valid: got %b, required 0", out_valid); end
        if (syndrome_valid !== 1'b0) begin n_err++; $display("[TB] FAIL abort_syn_valid: got %b, required 0", syndrome_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || syndrome_valid !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_err++; $display("[TB] FAIL abort_no_output: got %0d active cycles, required 0", stray); end
        randomize_check(5, 15);
        ready_mode = 2;
        compute_expected();
        send_check(DC, 1'b0);
        collect_check();
        for (int i = 0; i < DC; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_msg[i] !== exp_msg(i)) begin
                n_err++;
                $display("[TB] FAIL abort_new_check edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", i, got_idx[i], got_msg[i], i, exp_msg(i));
            end
        end
        n_cmp++;
        if (syndrome !== 1'(exp_syn)) begin n_err++; $display("[TB] FAIL abort_syndrome: got %b, required %0d", syndrome, exp_syn); end
    endtask

    task automatic test_random();
        ready_mode = 2;
        for (int k = 0; k < 15; k++) begin
            randomize_check(0, 15);
            compute_expected();
            send_check(DC, 1'b0);
            collect_check();
            for (int i = 0; i < DC; i++) begin
                n_cmp++;
                if (got_idx[i] !== i || got_msg[i] !== exp_msg(i)) begin
                    n_err++;
                    $display("[TB] FAIL random_%0d edge %0d: got idx=%0d msg=%h, required idx=%0d msg=%h", k, i, got_idx[i], got_msg[i], i, exp_msg(i));
                end
            end
            n_cmp += 3;
            if (syndrome !== 1'(exp_syn)) begin n_err++; $display("[TB] FAIL random_%0d_syndrome: got %b, required %0d", k, syndrome, exp_syn); end
            if (sv_cnt !== 1) begin n_err++; $display("[TB] FAIL random_%0d_syn_pulse: got %0d cycles, required 1", k, sv_cnt); end
            if (stall_err !== 0) begin n_err++; $display("[TB] FAIL random_%0d_stable: got %0d unstable stalls, required 0", k, stall_err); end
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_msg     = '0;
        out_ready  = 1'b1;
        ready_mode = 0;
        next_first = '0;
        test_reset();
        test_all_positive();
        test_mixed_signs();
        test_backpressure();
        test_offset_saturation();
        test_back_to_back();
        test_abort_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
